pixel_port_arbiter: RTL
=======================

Name: pixel_port_arbiter

Overview:
- Shares the single pixel-coordinate memory port of the framebuffer memory manager among NUM_CLIENTS requesters, for example a CPU bus bridge, a fill/blit engine and a sprite loader.
- Uses round-robin arbitration with one transaction in flight at a time.
- Converts each client's valid/ready request and single-cycle response pulse into the manager's level request and complete-pulse protocol.
- Also performs coordinate range checking and timeout recovery.

Parameters:
- NUM_CLIENTS, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 15, cycles in ISSUE without a completion before the transaction is aborted.
- SCREEN_W, 320, valid x range is 0..SCREEN_W-1.
- SCREEN_H, 240, valid y range is 0..SCREEN_H-1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- cli_req_valid  in  NUM_CLIENTS  per-client request valid.
- cli_req_write  in  NUM_CLIENTS  1 = write, 0 = read.
- cli_req_x  in  NUM_CLIENTS x 9  pixel x.
- cli_req_y  in  NUM_CLIENTS x 8  pixel y.
- cli_req_wdata  in  NUM_CLIENTS x 8  write data.
- cli_req_ready  out  NUM_CLIENTS  one-hot grant; the handshake completes on the edge where valid & ready.
- cli_rsp_valid  out  NUM_CLIENTS  one-cycle response pulse to the owning client.
- cli_rsp_rdata  out  8  read data; shared by all clients, qualified by cli_rsp_valid.
- cli_rsp_error  out  1  response error flag (range or timeout), qualified by cli_rsp_valid.
- mem_x  out  9  to the manager's memoryXCoord.
- mem_y  out  8  to the manager's memoryYCoord.
- mem_read_req  out  1  to memoryReadRequest.
- mem_write_req  out  1  to memoryWriteRequest.
- mem_wdata  out  8  to memoryWriteData.
- mem_rdata  in  8  from memoryReadData.
- mem_read_complete  in  1  from memoryReadComplete.
- mem_write_complete  in  1  from memoryWriteComplete.

Behaviour:
- Reset:
  - State is IDLE and the round-robin pointer is last = NUM_CLIENTS-1.
  - All outputs are 0: mem_x, mem_y, mem_wdata, mem_*_req, cli_rsp_*, and the timeout counter.
- States: IDLE, ISSUE, RECOVER.
- IDLE:
  - cli_req_ready is combinational and one-hot.
  - The grant goes to the first valid client searching from last+1 modulo NUM_CLIENTS.
  - On the handshake edge, the arbiter registers the owner index, op, x, y and wdata, and sets last = owner.
- Range check at grant:
  - If x >= SCREEN_W or y >= SCREEN_H, no memory request is issued.
  - Next cycle: cli_rsp_valid[owner] = 1 and cli_rsp_error = 1; go to RECOVER.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_write_req or mem_read_req (exactly one, matching op) is registered high from the first ISSUE cycle.
  - mem_x, mem_y and mem_wdata are held stable for the whole transaction.
- Completion:
  - On a cycle where the complete input matching op is 1, drop the request at the next edge.
  - Pulse cli_rsp_valid[owner] with error = 0, capturing mem_rdata into cli_rsp_rdata (reads only; the value is unchanged on writes).
  - Go to RECOVER.
  - A complete input that does not match op is ignored.
- Timeout:
  - The counter increments each ISSUE cycle.
  - When it reaches TIMEOUT_CYCLES without completion, drop the request, respond with error = 1 and rdata = 0, then go to RECOVER.
  - If completion and expiry occur in the same cycle, completion wins.
- RECOVER:
  - Lasts exactly 1 cycle with both mem requests low; this guarantees the manager sees a deasserted request before any new one.
  - Always goes to IDLE.
  - No grants are issued in ISSUE or RECOVER.
- Timing:
  - Best-case turnaround is handshake to mem request in 1 cycle; response comes 1 cycle after complete.
  - Back-to-back grants are spaced by at least ISSUE+RECOVER.
- Fairness:
  - A client holding valid after its response is served again only after every other valid client has been served once.
- Simultaneous valids are resolved by the round-robin rule only.
- A client deasserting valid before ready causes no effect.
- Response width: cli_rsp_valid is one-hot and never has more than one bit set.
- Reset mid-transaction: immediate return to reset values with no response pulse. The manager's own reset clears its state in the same cycle.

Decomposition:
- Package pixel_bus_pkg holds:
  - SCREEN_W and SCREEN_H constants, and the PIXEL_X_W = 9 and PIXEL_Y_W = 8 widths.
  - typedef arb_state_t (IDLE, ISSUE, RECOVER).
  - typedef pixel_req_t {write, x, y, wdata}.
- Sub-module rr_picker:
  - Combinational round-robin one-hot selector.
  - Inputs: valid vector, last index. Outputs: one-hot grant, grant index.
  - Reused later by the display-list scheduler.

Test Plan:
- Single read, client 1, (x=10, y=20), manager model returns 0x5A: mem_read_req rises the cycle after the handshake, x=10/y=20 are held, and cli_rsp_valid[1] pulses with rdata 0x5A and error 0.
- All 3 clients hold valid writes with wdata 0x11/0x22/0x33 from reset: grants occur in order 0, 1, 2, 0. Each write reaches the model exactly once per grant with the correct data, and RECOVER shows a 1-cycle request gap.
- Out-of-range requests at (x=320, y=0) and (x=0, y=240): no mem request is ever asserted, and an error response arrives 1 cycle after the handshake.
- Model never completes a write: request stays high 15 cycles then drops, and the response has error = 1. A following request by another client proceeds normally.
- Read whose completion arrives on exactly the 15th ISSUE cycle: the response has error = 0 with valid rdata.
- Reset asserted in the 2nd ISSUE cycle: the next cycle has all outputs 0 and no rsp pulse. After reset, the first grant goes to client 0.

Source files
------------

// File: rtl/pixel_bus_pkg.sv
// Shared types and constants for the framebuffer pixel port.
// Used by the port arbiter and the display-list scheduler.
package pixel_bus_pkg;

  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 240;
  localparam int PIXEL_X_W = 9;
  localparam int PIXEL_Y_W = 8;
  localparam int PIXEL_D_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RECOVER
  } arb_state_t;

  typedef struct packed {
    logic                 write;
    logic [PIXEL_X_W-1:0] x;
    logic [PIXEL_Y_W-1:0] y;
    logic [PIXEL_D_W-1:0] wdata;
  } pixel_req_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first valid requester
// searching upward from last+1, wrapping modulo N.
module rr_picker #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grantIdx
);

  int          c;
  logic [N-1:0] sh;

  // Walk from farthest to nearest so the nearest valid wins.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    c        = 0;
    sh       = '0;
    for (int off = N; off >= 1; off--) begin
      c = (int'(last) + off) % N;
      sh = valid >> c;
      if (sh[0]) begin
        grant    = N'(1) << c;
        grantIdx = IW'(c);
      end
    end
  end

endmodule

// File: rtl/pixel_port_arbiter.sv
// Round-robin arbiter sharing the framebuffer pixel port among
// several clients, one transaction in flight, with range/timeout.
module pixel_port_arbiter
  import pixel_bus_pkg::*;
#(
  parameter int NUM_CLIENTS    = 3,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int SCREEN_W       = 320,
  parameter int SCREEN_H       = 240
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_CLIENTS-1:0]         cli_req_valid,
  input  logic [NUM_CLIENTS-1:0]         cli_req_write,
  input  logic [NUM_CLIENTS*9-1:0]       cli_req_x,
  input  logic [NUM_CLIENTS*8-1:0]       cli_req_y,
  input  logic [NUM_CLIENTS*8-1:0]       cli_req_wdata,
  output logic [NUM_CLIENTS-1:0]         cli_req_ready,
  output logic [NUM_CLIENTS-1:0]         cli_rsp_valid,
  output logic [7:0]                     cli_rsp_rdata,
  output logic                           cli_rsp_error,
  output logic [8:0]                     mem_x,
  output logic [7:0]                     mem_y,
  output logic                           mem_read_req,
  output logic                           mem_write_req,
  output logic [7:0]                     mem_wdata,
  input  logic [7:0]                     mem_rdata,
  input  logic                           mem_read_complete,
  input  logic                           mem_write_complete
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t           state;
  arb_state_t           stateNext;
  logic [IW-1:0]        last;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        grantIdx;
  logic [NUM_CLIENTS-1:0] grant;
  logic [NUM_CLIENTS-1:0] ownerHot;
  pixel_req_t           cur;
  pixel_req_t           selReq;
  logic [CW-1:0]        toCount;
  logic                 handshake;
  logic                 inRange;
  logic                 done;
  logic                 expired;

  rr_picker #(
    .N  (NUM_CLIENTS),
    .IW (IW)
  ) uPicker (
    .valid    (cli_req_valid),
    .last     (last),
    .grant    (grant),
    .grantIdx (grantIdx)
  );

  always_comb begin
    selReq       = '0;
    selReq.write = cli_req_write[grantIdx];
    selReq.x     = cli_req_x[grantIdx*PIXEL_X_W +: PIXEL_X_W];
    selReq.y     = cli_req_y[grantIdx*PIXEL_Y_W +: PIXEL_Y_W];
    selReq.wdata = cli_req_wdata[grantIdx*PIXEL_D_W +: PIXEL_D_W];
  end

  assign cli_req_ready = (state == IDLE) ? grant : '0;
  assign handshake     = |(cli_req_ready & cli_req_valid);
  assign inRange       = (int'(selReq.x) < SCREEN_W) &&
                         (int'(selReq.y) < SCREEN_H);
  // A complete strobe for the other op is not ours.
  assign done          = cur.write ? mem_write_complete
                                   : mem_read_complete;
  assign expired       = toCount == CW'(TIMEOUT_CYCLES - 1);
  assign ownerHot      = NUM_CLIENTS'(1) << owner;

  assign mem_x     = cur.x;
  assign mem_y     = cur.y;
  assign mem_wdata = cur.wdata;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (handshake)
                 stateNext = inRange ? ISSUE : RECOVER;
      ISSUE:   if (done || expired)
                 stateNext = RECOVER;
      RECOVER: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      last          <= IW'(NUM_CLIENTS - 1);
      owner         <= '0;
      cur           <= '0;
      toCount       <= '0;
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      cli_rsp_valid <= '0;
      cli_rsp_rdata <= '0;
      cli_rsp_error <= 1'b0;
    end else begin
      state         <= stateNext;
      cli_rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (handshake) begin
            owner   <= grantIdx;
            last    <= grantIdx;
            cur     <= selReq;
            toCount <= '0;
            if (inRange) begin
              mem_write_req <= selReq.write;
              mem_read_req  <= !selReq.write;
            end else begin
              cli_rsp_valid <= grant;
              cli_rsp_error <= 1'b1;
              cli_rsp_rdata <= '0;
            end
          end
        end
        ISSUE: begin
          toCount <= toCount + CW'(1);
          if (done) begin
            mem_write_req <= 1'b0;
            mem_read_req  <= 1'b0;
            cli_rsp_valid <= ownerHot;
            cli_rsp_error <= 1'b0;
            if (!cur.write)
              cli_rsp_rdata <= mem_rdata;
          end else if (expired) begin
            mem_write_req <= 1'b0;
            mem_read_req  <= 1'b0;
            cli_rsp_valid <= ownerHot;
            cli_rsp_error <= 1'b1;
            cli_rsp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
